blink_monitor: RTL and testbench

- Receive-side counterpart of the LED blinking state machine: watches a blinking line and measures it.
- Takes an asynchronous blink line (LED output or a looped-back pin) into the system clock domain and measures high time and period in clk cycles.
- Counts completed blinks and flags a stuck line (no rising edge within a timeout).
- Used on-board as a self-check of the blinker and clock divider chain, with results routed to debug LEDs/7-seg.

---
 rtl/blink_monitor.sv | 138 +++++++++++++
 tb/tb_blink_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_monitor.sv
// Measures the period and high time of an asynchronous blink line in clk cycles,
// counts completed blinks and flags a line that stops toggling.
module blink_monitor #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 100000000,
    parameter int unsigned BCNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              blink_in,
    output logic              level,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              meas_valid,
    output logic [BCNT_W-1:0] blink_count,
    output logic              stuck
);

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    logic              s1_q, s2_q, s2_d_q;
    logic              rise, fall, timeout;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_time_q, high_time_d;
    logic              meas_valid_q, meas_valid_d;
    logic [BCNT_W-1:0] blink_count_q, blink_count_d;
    logic              stuck_q, stuck_d;

    // Synchronizer runs regardless of enable so level stays live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s2_d_q <= 1'b0;
        end else begin
            s1_q   <= blink_in;
            s2_q   <= s1_q;
            s2_d_q <= s2_q;
        end
    end

    assign rise    = s2_q & ~s2_d_q;
    assign fall    = ~s2_q & s2_d_q;
    assign timeout = (cnt_q == TimeoutVal) && !rise;

    // The arming rise restarts the count too, so the first period comes out exact.
    always_comb begin
        if (!enable) begin
            cnt_d = '0;
        end else if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        hi_lat_d      = hi_lat_q;
        period_d      = period_q;
        high_time_d   = high_time_q;
        meas_valid_d  = 1'b0;
        blink_count_d = blink_count_q;
        stuck_d       = stuck_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rise) state_d = StHigh;
                end
                StHigh: begin
                    if (timeout) begin
                        state_d = StIdle;
                        stuck_d = 1'b1;
                    end else if (fall) begin
                        state_d  = StLow;
                        hi_lat_d = cnt_q;
                    end
                end
                StLow: begin
                    if (rise) begin
                        state_d       = StHigh;
                        period_d      = cnt_q;
                        high_time_d   = hi_lat_q;
                        meas_valid_d  = 1'b1;
                        blink_count_d = blink_count_q + BCNT_W'(1);
                        stuck_d       = 1'b0;
                    end else if (timeout) begin
                        state_d = StIdle;
                        stuck_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            hi_lat_q      <= '0;
            period_q      <= '0;
            high_time_q   <= '0;
            meas_valid_q  <= 1'b0;
            blink_count_q <= '0;
            stuck_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_lat_q      <= hi_lat_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            meas_valid_q  <= meas_valid_d;
            blink_count_q <= blink_count_d;
            stuck_q       <= stuck_d;
        end
    end

    assign level       = s2_q;
    assign period      = period_q;
    assign high_time   = high_time_q;
    assign meas_valid  = meas_valid_q;
    assign blink_count = blink_count_q;
    assign stuck       = stuck_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Scoreboard bench for blink_monitor: stimulus pushes expected measurements,
// a forked monitor pops and compares on every meas_valid pulse.
module tb_blink_monitor;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 50;
    localparam int unsigned BCNT_W  = 2;

    typedef struct {
        logic [CNT_W-1:0]  p;
        logic [CNT_W-1:0]  h;
        logic [BCNT_W-1:0] bc;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              blink_in;
    logic              level;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  high_time;
    logic              meas_valid;
    logic [BCNT_W-1:0] blink_count;
    logic              stuck;

    exp_t              sb_q[$];
    logic [BCNT_W-1:0] bc_model;
    int                n_tests;
    int                n_fail;
    int                phase;
    int                cyc;
    int                last_rise_cyc;
    int                stuck_cycles;
    int                s0;

    blink_monitor #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT),
        .BCNT_W (BCNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .blink_in   (blink_in),
        .level      (level),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .blink_count(blink_count),
        .stuck      (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (stuck) stuck_cycles++;
            if (!reset && meas_valid) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_meas: got meas_valid=1 period=%0d expected no measurement (t=%0t)",
                             period, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("meas_period", 32'(period), 32'(e.p));
                    check("meas_high_time", 32'(high_time), 32'(e.h));
                    check("meas_blink_count", 32'(blink_count), 32'(e.bc));
                    check("meas_stuck_clear", 32'(stuck), 32'd0);
                end
            end
        end
    endtask

    // Advance n clock edges, then settle phase ns after the edge where inputs change.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #phase;
    endtask

    task automatic push(input int p, input int h);
        exp_t e;
        bc_model = bc_model + 1'b1;
        e.p  = CNT_W'(p);
        e.h  = CNT_W'(h);
        e.bc = bc_model;
        sb_q.push_back(e);
    endtask

    // n periods of p cycles, high for h; with arm set the first rise only arms.
    task automatic square(input int p, input int h, input int n, input bit arm);
        for (int i = 0; i < n; i++) begin
            blink_in      = 1'b1;
            last_rise_cyc = cyc;
            if (!(arm && i == 0)) push(p, h);
            wait_cyc(h);
            blink_in = 1'b0;
            wait_cyc(p - h);
        end
    endtask

    task automatic force_idle();
        enable = 1'b0;
        wait_cyc(2);
        enable = 1'b1;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        bc_model     = '0;
        stuck_cycles = 0;
        phase        = int'($urandom_range(1, 6));
        reset        = 1'b1;
        enable       = 1'b0;
        blink_in     = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        #2;
        check("rst_level", 32'(level), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_high_time", 32'(high_time), 32'd0);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        check("rst_blink_count", 32'(blink_count), 32'd0);
        check("rst_stuck", 32'(stuck), 32'd0);
        wait_cyc(2);
        reset  = 1'b0;
        enable = 1'b1;
        wait_cyc(3);

        // Square wave 20/8, five periods: four measurements
        square(20, 8, 5, 1'b1);
        check("sq_blink_count", 32'(blink_count), 32'd0);
        check("sq_period", 32'(period), 32'd20);
        check("sq_high_time", 32'(high_time), 32'd8);

        // Timeout after the last rise
        wait (cyc == last_rise_cyc + 52);
        #1;
        check("stuck_before_timeout", 32'(stuck), 32'd0);
        wait (cyc == last_rise_cyc + 53);
        #1;
        check("stuck_at_timeout", 32'(stuck), 32'd1);
        check("period_hold_stuck", 32'(period), 32'd20);
        wait_cyc(1);
        square(20, 8, 1, 1'b1);
        check("stuck_after_arm", 32'(stuck), 32'd1);
        square(20, 8, 1, 1'b0);
        check("stuck_cleared", 32'(stuck), 32'd0);

        // Boundary: spacing == TIMEOUT measures, spacing TIMEOUT+1 times out
        force_idle();
        s0 = stuck_cycles;
        square(50, 10, 3, 1'b1);
        check("no_stuck_at_boundary", 32'(stuck_cycles - s0), 32'd0);
        wait_cyc(1);
        blink_in = 1'b1;
        wait_cyc(10);
        blink_in = 1'b0;
        wait_cyc(10);
        check("stuck_spacing_51", 32'(stuck), 32'd1);
        check("period_boundary", 32'(period), 32'd50);
        check("high_time_boundary", 32'(high_time), 32'd10);

        // Async reset mid-cycle with the line toggling
        wait_cyc(40);
        blink_in = 1'b1;
        wait_cyc(4);
        #2;
        reset    = 1'b1;
        blink_in = 1'b0;
        bc_model = '0;
        #1;
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_period", 32'(period), 32'd0);
        check("async_rst_high_time", 32'(high_time), 32'd0);
        check("async_rst_blink_count", 32'(blink_count), 32'd0);
        check("async_rst_stuck", 32'(stuck), 32'd0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(3);

        // Wrap: six periods give blink_count 1,2,3,0,1
        square(20, 8, 6, 1'b1);
        check("wrap_blink_count", 32'(blink_count), 32'd1);

        // Enable drop mid-blink
        blink_in = 1'b1;
        push(20, 8);
        wait_cyc(4);
        enable = 1'b0;
        wait_cyc(4);
        check("dis_level_high", 32'(level), 32'd1);
        blink_in = 1'b0;
        wait_cyc(6);
        check("dis_level_low", 32'(level), 32'd0);
        check("dis_period_hold", 32'(period), 32'd20);
        check("dis_high_time_hold", 32'(high_time), 32'd8);
        check("dis_blink_count_hold", 32'(blink_count), 32'd2);
        enable = 1'b1;
        wait_cyc(6);
        square(20, 8, 2, 1'b1);
        check("reenable_blink_count", 32'(blink_count), 32'd3);

        // Minimum pulse: one cycle high every four
        force_idle();
        square(4, 1, 5, 1'b1);
        check("min_period", 32'(period), 32'd4);
        check("min_high_time", 32'(high_time), 32'd1);
        wait_cyc(10);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
